id_operand_stage: RTL and testbench

Decode-stage operand collector and ID/EX pipeline register for the five-stage MIPS core. It drives the register file's two read ports, resolves RAW hazards against instructions in EX and MEM, and raises a stall request on unresolved hazards. It registers the resolved operands and control into the ID/EX boundary consumed by the EX stage.

---
 rtl/id_operand_stage_pkg.sv | 26 ++
 rtl/id_operand_stage_fwd_mux.sv | 71 +++++++
 rtl/id_operand_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_operand_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_operand_stage_pkg
// Shared definitions for the decode-stage operand collector:
//   - default register-address / data / aluop widths
//   - aluop encodings (ALUOP_NOP is what a bubble or flush leaves in ID/EX)
//   - hazard FSM state type (RUN, BUBBLE)
// Optional feature macro used by the slice: ID_FWD_EN (EX/MEM forwarding).
// ---------------------------------------------------------------------------
package id_operand_stage_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int DW_DEF     = 32;
   localparam int OPW_DEF    = 8;

   localparam logic [7:0] ALUOP_NOP = 8'h00;
   localparam logic [7:0] ALUOP_AND = 8'h24;
   localparam logic [7:0] ALUOP_OR  = 8'h25;
   localparam logic [7:0] ALUOP_ADD = 8'h20;
   localparam logic [7:0] ALUOP_SUB = 8'h22;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } id_state_e;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Selects one source operand and reports whether an in-flight writer in EX
// or MEM targets the same register.
// Feature macro: ID_FWD_EN. When defined, an EX match beats a MEM match,
// which beats register-file data. When undefined, only register-file data
// is used and the match flags serve hazard detection alone.
// Ports:
//   en                        operand is actually read
//   src                       source register address
//   rdata                     register-file read data
//   ex_wreg/ex_wd/ex_wdata    EX-stage writer
//   mem_wreg/mem_wd/mem_wdata MEM-stage writer
//   operand                   resolved operand (0 when unread or src == 0)
//   ex_match/mem_match        writer targets src (never for src == 0)
// ---------------------------------------------------------------------------
module fwd_mux #(
   parameter int REG_AW = 5,
   parameter int DW     = 32
) (
   input  logic              en,
   input  logic [REG_AW-1:0] src,
   input  logic [DW-1:0]     rdata,
   input  logic              ex_wreg,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic [DW-1:0]     ex_wdata,
   input  logic              mem_wreg,
   input  logic [REG_AW-1:0] mem_wd,
   input  logic [DW-1:0]     mem_wdata,
   output logic [DW-1:0]     operand,
   output logic              ex_match,
   output logic              mem_match
);

   logic src_live_s;

   // $0 is hard-wired to zero, so it never matches a writer.
   assign src_live_s = en & (src != {REG_AW{1'b0}});
   assign ex_match   = src_live_s & ex_wreg  & (ex_wd  == src);
   assign mem_match  = src_live_s & mem_wreg & (mem_wd == src);

`ifdef ID_FWD_EN
   // Youngest writer first: EX, then MEM, then register file.
   always_comb begin
      operand = {DW{1'b0}};
      if (!src_live_s) begin
         operand = {DW{1'b0}};
      end else if (ex_match) begin
         operand = ex_wdata;
      end else if (mem_match) begin
         operand = mem_wdata;
      end else begin
         operand = rdata;
      end
   end
`else
   logic unused_wdata_s;
   assign unused_wdata_s = ^{ex_wdata, mem_wdata};

   // Without forwarding the hazard logic stalls until rdata is current.
   always_comb begin
      operand = {DW{1'b0}};
      if (src_live_s) begin
         operand = rdata;
      end else begin
         operand = {DW{1'b0}};
      end
   end
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ---------------------------------------------------------------------------
// id_operand_stage
// Decode-stage operand collector and ID/EX pipeline register.
// Drives the register-file read ports, resolves RAW hazards against EX and
// MEM writers, requests an upstream stall on unresolved hazards and
// registers the resolved operands and control for the EX stage.
// Feature macro: ID_FWD_EN
//   defined   - forward from EX/MEM; only a load-use in EX stalls (1 bubble)
//   undefined - no forwarding; any EX/MEM match stalls (up to 2 bubbles)
// Ports:
//   clk, rst (async, active-high)
//   id_valid_i, use_rs_i, use_rt_i, rs_i, rt_i, use_imm_i, imm_i,
//   aluop_i, wd_i, wreg_i                      decoded instruction
//   re1/re2, raddr1/raddr2, rdata1/rdata2      register-file read ports
//   ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  EX-stage writer
//   mem_wreg_i, mem_wd_i, mem_wdata_i          MEM-stage writer
//   stall_i (hold ID/EX), flush_i (clear ID/EX)
//   stall_req_o                                hold IF/ID upstream
//   ex_valid_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o
// ---------------------------------------------------------------------------
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int OPW    = OPW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic              use_rs_i,
   input  logic              use_rt_i,
   input  logic [REG_AW-1:0] rs_i,
   input  logic [REG_AW-1:0] rt_i,
   input  logic              use_imm_i,
   input  logic [DW-1:0]     imm_i,
   input  logic [OPW-1:0]    aluop_i,
   input  logic [REG_AW-1:0] wd_i,
   input  logic              wreg_i,
   output logic              re1,
   output logic              re2,
   output logic [REG_AW-1:0] raddr1,
   output logic [REG_AW-1:0] raddr2,
   input  logic [DW-1:0]     rdata1,
   input  logic [DW-1:0]     rdata2,
   input  logic              ex_wreg_i,
   input  logic [REG_AW-1:0] ex_wd_i,
   input  logic [DW-1:0]     ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_wreg_i,
   input  logic [REG_AW-1:0] mem_wd_i,
   input  logic [DW-1:0]     mem_wdata_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              stall_req_o,
   output logic              ex_valid_o,
   output logic [OPW-1:0]    ex_aluop_o,
   output logic [DW-1:0]     ex_reg1_o,
   output logic [DW-1:0]     ex_reg2_o,
   output logic [REG_AW-1:0] ex_wd_o,
   output logic              ex_wreg_o
);

   localparam logic [OPW-1:0] BUBBLE_OP = OPW'(ALUOP_NOP);

   logic          op1_s;
   logic [DW-1:0] op1_val_s;
   logic [DW-1:0] op2_val_s;
   logic [DW-1:0] reg2_s;
   logic          ex_match1_s, ex_match2_s;
   logic          mem_match1_s, mem_match2_s;
   logic          hazard_raw_s;
   logic          hazard_s;
   id_state_e     state_r;

   // rt is not read at all when the immediate replaces operand 2.
   assign re1    = id_valid_i & use_rs_i;
   assign re2    = id_valid_i & use_rt_i & ~use_imm_i;
   assign raddr1 = rs_i;
   assign raddr2 = rt_i;
   assign op1_s  = re1;

   fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd1 (
      .en        (op1_s),
      .src       (rs_i),
      .rdata     (rdata1),
      .ex_wreg   (ex_wreg_i),
      .ex_wd     (ex_wd_i),
      .ex_wdata  (ex_wdata_i),
      .mem_wreg  (mem_wreg_i),
      .mem_wd    (mem_wd_i),
      .mem_wdata (mem_wdata_i),
      .operand   (op1_val_s),
      .ex_match  (ex_match1_s),
      .mem_match (mem_match1_s)
   );

   fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd2 (
      .en        (re2),
      .src       (rt_i),
      .rdata     (rdata2),
      .ex_wreg   (ex_wreg_i),
      .ex_wd     (ex_wd_i),
      .ex_wdata  (ex_wdata_i),
      .mem_wreg  (mem_wreg_i),
      .mem_wd    (mem_wd_i),
      .mem_wdata (mem_wdata_i),
      .operand   (op2_val_s),
      .ex_match  (ex_match2_s),
      .mem_match (mem_match2_s)
   );

`ifdef ID_FWD_EN
   logic unused_mem_match_s;
   assign unused_mem_match_s = mem_match1_s ^ mem_match2_s;
   // Only a load still in EX has no data to forward yet.
   assign hazard_raw_s = (ex_match1_s | ex_match2_s) & ex_is_load_i;
`else
   logic unused_is_load_s;
   assign unused_is_load_s = ex_is_load_i;
   assign hazard_raw_s = ex_match1_s | ex_match2_s | mem_match1_s | mem_match2_s;
`endif

   // Stall request never leaks out while idle or while in reset.
   assign hazard_s    = hazard_raw_s & id_valid_i & ~rst;
   assign stall_req_o = hazard_s;

   // Operand 2 source: immediate overrides the rt read path.
   always_comb begin
      reg2_s = {DW{1'b0}};
      if (use_imm_i) begin
         reg2_s = imm_i;
      end else begin
         reg2_s = op2_val_s;
      end
   end

   // Hazard FSM: BUBBLE while a hazard persists, RUN once it clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (hazard_s) state_r <= ST_BUBBLE;
               else          state_r <= ST_RUN;
            end
            ST_BUBBLE: begin
               if (hazard_s) state_r <= ST_BUBBLE;
               else          state_r <= ST_RUN;
            end
            default: state_r <= ST_RUN;
         endcase
      end
   end

   // ID/EX register: flush > downstream stall > hazard bubble > load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_o <= 1'b0;
         ex_aluop_o <= BUBBLE_OP;
         ex_reg1_o  <= {DW{1'b0}};
         ex_reg2_o  <= {DW{1'b0}};
         ex_wd_o    <= {REG_AW{1'b0}};
         ex_wreg_o  <= 1'b0;
      end else if (flush_i || (!stall_i && hazard_s)) begin
         ex_valid_o <= 1'b0;
         ex_aluop_o <= BUBBLE_OP;
         ex_reg1_o  <= {DW{1'b0}};
         ex_reg2_o  <= {DW{1'b0}};
         ex_wd_o    <= {REG_AW{1'b0}};
         ex_wreg_o  <= 1'b0;
      end else if (stall_i) begin
         ex_valid_o <= ex_valid_o;
         ex_aluop_o <= ex_aluop_o;
         ex_reg1_o  <= ex_reg1_o;
         ex_reg2_o  <= ex_reg2_o;
         ex_wd_o    <= ex_wd_o;
         ex_wreg_o  <= ex_wreg_o;
      end else begin
         ex_valid_o <= id_valid_i;
         ex_aluop_o <= aluop_i;
         ex_reg1_o  <= op1_val_s;
         ex_reg2_o  <= reg2_s;
         ex_wd_o    <= wd_i;
         ex_wreg_o  <= wreg_i;
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

   typedef struct packed {
      logic        v;
      logic [7:0]  op;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        w;
   } idex_t;

`ifdef ID_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid_i, use_rs_i, use_rt_i, use_imm_i, wreg_i;
   logic [4:0]  rs_i, rt_i, wd_i;
   logic [31:0] imm_i;
   logic [7:0]  aluop_i;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        stall_i, flush_i, stall_req_o;
   logic        ex_valid_o, ex_wreg_o;
   logic [7:0]  ex_aluop_o;
   logic [31:0] ex_reg1_o, ex_reg2_o;
   logic [4:0]  ex_wd_o;

   int    n_checks = 0;
   int    n_errors = 0;
   idex_t exp_q[$];
   idex_t model_r;
   logic  last_hazard;

   id_operand_stage dut (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid_i), .use_rs_i(use_rs_i), .use_rt_i(use_rt_i),
      .rs_i(rs_i), .rt_i(rt_i), .use_imm_i(use_imm_i), .imm_i(imm_i),
      .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
      .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o),
      .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
      .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference operand resolution: EX over MEM over regfile, $0 -> 0.
   function automatic logic [31:0] m_resolve(input logic en, input logic [4:0] src,
                                             input logic [31:0] rdata);
      if (!en || src == 5'd0) return 32'd0;
      if (FWD && ex_wreg_i && ex_wd_i == src) return ex_wdata_i;
      if (FWD && mem_wreg_i && mem_wd_i == src) return mem_wdata_i;
      return rdata;
   endfunction

   function automatic logic m_hazard();
      logic e1, e2, x1, x2, m1, m2;
      e1 = id_valid_i && use_rs_i && rs_i != 5'd0;
      e2 = id_valid_i && use_rt_i && !use_imm_i && rt_i != 5'd0;
      x1 = e1 && ex_wreg_i && ex_wd_i == rs_i;
      x2 = e2 && ex_wreg_i && ex_wd_i == rt_i;
      m1 = e1 && mem_wreg_i && mem_wd_i == rs_i;
      m2 = e2 && mem_wreg_i && mem_wd_i == rt_i;
      if (rst) return 1'b0;
      if (FWD) return (x1 || x2) && ex_is_load_i;
      return x1 || x2 || m1 || m2;
   endfunction

   task automatic clear_inputs();
      id_valid_i = 1'b0; use_rs_i = 1'b0; use_rt_i = 1'b0; use_imm_i = 1'b0;
      wreg_i = 1'b0; rs_i = 5'd0; rt_i = 5'd0; wd_i = 5'd0; imm_i = 32'd0;
      aluop_i = 8'd0; rdata1 = 32'd0; rdata2 = 32'd0;
      ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'd0; ex_is_load_i = 1'b0;
      mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'd0;
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input idex_t e);
      chk({tag, ".valid"}, 64'(ex_valid_o), 64'(e.v));
      chk({tag, ".aluop"}, 64'(ex_aluop_o), 64'(e.op));
      chk({tag, ".reg1"},  64'(ex_reg1_o),  64'(e.r1));
      chk({tag, ".reg2"},  64'(ex_reg2_o),  64'(e.r2));
      chk({tag, ".wd"},    64'(ex_wd_o),    64'(e.wd));
      chk({tag, ".wreg"},  64'(ex_wreg_o),  64'(e.w));
   endtask

   // One cycle: check combinational outputs, push expected ID/EX, clock, pop and compare.
   task automatic step(input string tag);
      idex_t e;
      logic  h;
      #1;
      h = m_hazard();
      chk({tag, ".stall_req"}, 64'(stall_req_o), 64'(h));
      chk({tag, ".re"}, 64'({re1, re2}),
          64'({id_valid_i & use_rs_i, id_valid_i & use_rt_i & ~use_imm_i}));
      chk({tag, ".raddr"}, 64'({raddr1, raddr2}), 64'({rs_i, rt_i}));
      if (flush_i) e = '0;
      else if (stall_i) e = model_r;
      else if (h) e = '0;
      else begin
         e.v  = id_valid_i;
         e.op = aluop_i;
         e.r1 = m_resolve(id_valid_i & use_rs_i, rs_i, rdata1);
         e.r2 = use_imm_i ? imm_i : m_resolve(id_valid_i & use_rt_i, rt_i, rdata2);
         e.wd = wd_i;
         e.w  = wreg_i;
      end
      exp_q.push_back(e);
      last_hazard = h;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      model_r = e;
      check_outputs(tag, e);
   endtask

   // Writer to r moves EX -> MEM -> WB each stalled cycle; count bubbles.
   task automatic dep_test(input string tag, input bit on_rt, input logic [4:0] r,
                           input logic [31:0] newv, input bit is_load, input int exp_bubbles);
      int p = 0;
      int bubbles = 0;
      clear_inputs();
      id_valid_i = 1'b1; aluop_i = 8'h20; wd_i = 5'd9; wreg_i = 1'b1;
      if (on_rt) begin use_rt_i = 1'b1; rt_i = r; end
      else begin use_rs_i = 1'b1; rs_i = r; end
      for (int c = 0; c < 5; c++) begin
         ex_wreg_i    = (p == 0);
         ex_wd_i      = r;
         ex_wdata_i   = is_load ? 32'h0BAD_0BAD : newv;
         ex_is_load_i = is_load && (p == 0);
         mem_wreg_i   = (p == 1);
         mem_wd_i     = r;
         mem_wdata_i  = newv;
         rdata1       = (p >= 2) ? newv : 32'h0000_DEAD;
         rdata2       = rdata1;
         step(tag);
         if (last_hazard) begin
            bubbles++;
            p++;
         end else begin
            break;
         end
      end
      chk({tag, ".bubbles"}, 64'(bubbles), 64'(exp_bubbles));
      chk({tag, ".value"}, 64'(on_rt ? ex_reg2_o : ex_reg1_o), 64'(newv));
      chk({tag, ".valid_after"}, 64'(ex_valid_o), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_r = '0;
      last_hazard = 1'b0;

      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         id_valid_i = 1'b1; use_rs_i = 1'b1; use_rt_i = 1'b1;
         rs_i = 5'($urandom_range(1, 3)); rt_i = rs_i;
         ex_wreg_i = 1'b1; ex_wd_i = rs_i; ex_is_load_i = 1'b1;
         mem_wreg_i = 1'b1; mem_wd_i = rs_i;
         aluop_i = 8'($urandom); wd_i = 5'($urandom); wreg_i = 1'b1;
         rdata1 = $urandom; rdata2 = $urandom; imm_i = $urandom;
         @(posedge clk);
         #1;
         chk("reset.stall_req", 64'(stall_req_o), 64'd0);
         check_outputs("reset", '0);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;

      // Forward from EX (non-load).
      dep_test("ex_fwd", 1'b0, 5'd3, 32'h0000_1234, 1'b0, FWD ? 0 : 2);
      clear_inputs(); step("idle1");

      // Load-use on rt.
      dep_test("load_use", 1'b1, 5'd7, 32'hCAFE_0007, 1'b1, FWD ? 1 : 2);
      clear_inputs(); step("idle2");

      // EX and MEM both write $5; EX value must win.
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; use_rt_i = 1'b1; rs_i = 5'd5; rt_i = 5'd5;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_wdata_i = 32'h0000_AAAA;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd5; mem_wdata_i = 32'h0000_BBBB;
      rdata1 = 32'h0000_5555; rdata2 = 32'h0000_5555;
      step("ex_over_mem");
      if (FWD) begin
         chk("ex_over_mem.r1", 64'(ex_reg1_o), 64'h0000_AAAA);
         chk("ex_over_mem.r2", 64'(ex_reg2_o), 64'h0000_AAAA);
      end

      // rs via EX, rt via MEM.
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; use_rt_i = 1'b1; rs_i = 5'd4; rt_i = 5'd6;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h0000_1111;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd6; mem_wdata_i = 32'h0000_2222;
      rdata1 = 32'h0000_0A0A; rdata2 = 32'h0000_0B0B;
      step("split_fwd");

      // $0 is never forwarded and never stalls.
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; use_rt_i = 1'b1; aluop_i = 8'h25;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'h0000_FFFF; ex_is_load_i = 1'b1;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd0; mem_wdata_i = 32'h0000_EEEE;
      rdata1 = 32'h0000_1357; rdata2 = 32'h0000_2468;
      step("reg0");
      chk("reg0.r1", 64'(ex_reg1_o), 64'd0);
      chk("reg0.r2", 64'(ex_reg2_o), 64'd0);

      // Immediate replaces rt: a load to rt is no hazard.
      clear_inputs();
      id_valid_i = 1'b1; use_rt_i = 1'b1; use_imm_i = 1'b1; rt_i = 5'd8;
      imm_i = 32'hFFFF_FFF0; ex_wreg_i = 1'b1; ex_wd_i = 5'd8; ex_is_load_i = 1'b1;
      step("imm");
      chk("imm.r2", 64'(ex_reg2_o), 64'hFFFF_FFF0);

      // Load a valid instruction, then hold it with stall_i.
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; rs_i = 5'd2; rdata1 = 32'h0000_00C3;
      aluop_i = 8'h22; wd_i = 5'd11; wreg_i = 1'b1;
      step("load_a");
      rs_i = 5'd1; rdata1 = 32'h0000_0099; wd_i = 5'd12; stall_i = 1'b1;
      step("hold");
      chk("hold.r1", 64'(ex_reg1_o), 64'h0000_00C3);

      // flush_i and stall_i together clear.
      flush_i = 1'b1;
      step("flush_stall");
      chk("flush_stall.valid", 64'(ex_valid_o), 64'd0);

      // Async reset mid-stall clears immediately.
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; rs_i = 5'd2; rdata1 = 32'h0000_0077; wreg_i = 1'b1;
      step("pre_rst");
      stall_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_is_load_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.valid", 64'(ex_valid_o), 64'd0);
      chk("async_rst.r1", 64'(ex_reg1_o), 64'd0);
      chk("async_rst.stall_req", 64'(stall_req_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_r = '0;
      clear_inputs();
      id_valid_i = 1'b1; use_rs_i = 1'b1; rs_i = 5'd2; rdata1 = 32'h0000_0042;
      step("post_rst");
      chk("post_rst.r1", 64'(ex_reg1_o), 64'h0000_0042);

      // Random traffic with a small register set for frequent matches.
      for (int i = 0; i < 60; i++) begin
         id_valid_i = 1'($urandom); use_rs_i = 1'($urandom); use_rt_i = 1'($urandom);
         use_imm_i = ($urandom_range(0, 3) == 0);
         rs_i = 5'($urandom_range(0, 3)); rt_i = 5'($urandom_range(0, 3));
         imm_i = $urandom; aluop_i = 8'($urandom); wd_i = 5'($urandom); wreg_i = 1'($urandom);
         rdata1 = $urandom; rdata2 = $urandom;
         ex_wreg_i = 1'($urandom); ex_wd_i = 5'($urandom_range(0, 3));
         ex_wdata_i = $urandom; ex_is_load_i = 1'($urandom);
         mem_wreg_i = 1'($urandom); mem_wd_i = 5'($urandom_range(0, 3));
         mem_wdata_i = $urandom;
         stall_i = ($urandom_range(0, 7) == 0); flush_i = ($urandom_range(0, 9) == 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
